// File: rtl/ahb_refill_master.sv
// AHB-Lite read master for I-cache line refills: one INCR4 word burst per
// request, assembled into a 128-bit line and returned with a ready pulse.
module ahb_refill_master #(
  parameter logic [3:0] HPROT_VAL = 4'b1000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mem_req_i,
  input  logic [31:0]  mem_addr_i,
  output logic [127:0] mem_data_o,
  output logic         mem_ready_o,
  output logic         mem_err_o,
  output logic [31:0]  haddr_o,
  output logic [1:0]   htrans_o,
  output logic [2:0]   hburst_o,
  output logic [2:0]   hsize_o,
  output logic         hwrite_o,
  output logic [3:0]   hprot_o,
  input  logic [31:0]  hrdata_i,
  input  logic         hready_i,
  input  logic         hresp_i
);

  localparam int NUM_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS      = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  acnt_q, acnt_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        cancel_q, cancel_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        clr_data;
  logic [NUM_BEATS-1:0]       cap_en;
  logic [NUM_BEATS-1:0][31:0] data_q;
  logic        addr_act;

  // An address phase is on the bus only while beats remain and no ERROR
  // has been seen; a cancelled burst drops straight to IDLE.
  assign addr_act = (state_q == ST_BUS) && (acnt_q < 3'd4) && !cancel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      acnt_q   <= '0;
      dcnt_q   <= '0;
      cancel_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      acnt_q   <= acnt_d;
      dcnt_q   <= dcnt_d;
      cancel_q <= cancel_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acnt_d   = acnt_q;
    dcnt_d   = dcnt_q;
    cancel_d = cancel_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    clr_data = 1'b0;
    cap_en   = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          base_d   = {mem_addr_i[31:4], 4'h0};
          acnt_d   = '0;
          dcnt_d   = '0;
          cancel_d = 1'b0;
          clr_data = 1'b1;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        if (hready_i) begin
          if (hresp_i) begin
            // second ERROR cycle: abort with whatever words arrived
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_WAIT_REL;
          end else begin
            if (dcnt_q < acnt_q) begin
              cap_en[dcnt_q[1:0]] = 1'b1;
              dcnt_d = dcnt_q + 3'd1;
              if (dcnt_q == 3'd3) begin
                ready_d = 1'b1;
                state_d = ST_WAIT_REL;
              end
            end
            if (addr_act) acnt_d = acnt_q + 3'd1;
          end
        end else if (hresp_i) begin
          cancel_d = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!mem_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NUM_BEATS; k++) begin : g_word
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        data_q[k] <= '0;
        else if (clr_data)  data_q[k] <= '0;
        else if (cap_en[k]) data_q[k] <= hrdata_i;
      end
    end
  endgenerate

  assign mem_data_o  = data_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;

  // Line-aligned base: the beat index only touches bits [3:2], so no carry
  // can leave the 16-byte line.
  assign haddr_o  = addr_act ? {base_q[31:4], acnt_q[1:0], 2'b00} : 32'h0;
  assign htrans_o = !addr_act      ? HTRANS_IDLE :
                    (acnt_q == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign hburst_o = 3'b011;
  assign hsize_o  = 3'b010;
  assign hwrite_o = 1'b0;
  assign hprot_o  = HPROT_VAL;

endmodule

// File: tb/tb_ahb_refill_master.sv
// Randomized bench for ahb_refill_master: a behavioural AHB slave with
// configurable wait states / ERROR beat, and a per-request line/latency model.
module tb_ahb_refill_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_ready, mem_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst, hsize;
  logic         hwrite;
  logic [3:0]   hprot;
  logic [31:0]  hrdata;
  logic         hready, hresp;

  int n_chk = 0;
  int n_err = 0;

  // slave configuration for the current request
  int          cfg_wait [4];
  int          cfg_err;
  logic [31:0] cfg_data [4];
  logic [31:0] exp_base;

  // slave bookkeeping
  int          acc_cnt;
  bit          dp_valid, err2;
  int          dp_beat, wait_left;
  logic [1:0]  t_prev;
  logic [31:0] a_prev;

  ahb_refill_master #(.HPROT_VAL(4'b1000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
    .mem_data_o(mem_data), .mem_ready_o(mem_ready), .mem_err_o(mem_err),
    .haddr_o(haddr), .htrans_o(htrans), .hburst_o(hburst), .hsize_o(hsize),
    .hwrite_o(hwrite), .hprot_o(hprot), .hrdata_i(hrdata), .hready_i(hready),
    .hresp_i(hresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: at each falling edge, account for the rising edge just passed,
  // then drive hready/hresp/hrdata for the next one.
  always @(negedge clk) begin
    logic [31:0] ea;
    if (!rst_n) begin
      dp_valid = 0; err2 = 0; acc_cnt = 0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
    end else begin
      if (hready) begin
        dp_valid = 0;
        err2     = 0;
        if (t_prev != 2'b00) begin
          if (acc_cnt < 4) begin
            ea = exp_base + 32'(4 * acc_cnt);
            chk("acc_addr", a_prev, ea);
            chk("acc_trans", t_prev, (acc_cnt == 0) ? 2'b10 : 2'b11);
            dp_valid  = 1;
            dp_beat   = acc_cnt;
            wait_left = cfg_wait[acc_cnt];
          end else begin
            chk("extra_beat", acc_cnt, 3);
          end
          acc_cnt++;
        end
      end else if (hresp) begin
        err2 = 1;
        chk("cancel_idle", htrans, 2'b00);
      end else begin
        wait_left--;
        chk("hold_addr", haddr, a_prev);
        chk("hold_trans", htrans, t_prev);
      end
      hrdata = $urandom;
      if (!dp_valid) begin
        hready = 1'b1; hresp = 1'b0;
      end else if (err2) begin
        hready = 1'b1; hresp = 1'b1;
      end else if (wait_left > 0) begin
        hready = 1'b0; hresp = 1'b0;
      end else if (dp_beat == cfg_err) begin
        hready = 1'b0; hresp = 1'b1;
      end else begin
        hready = 1'b1; hresp = 1'b0; hrdata = cfg_data[dp_beat];
      end
    end
    t_prev = htrans;
    a_prev = haddr;
  end

  task automatic set_cfg(input int w0, input int w1, input int w2, input int w3, input int e);
    cfg_wait[0] = w0; cfg_wait[1] = w1; cfg_wait[2] = w2; cfg_wait[3] = w3;
    cfg_err = e;
    for (int i = 0; i < 4; i++) cfg_data[i] = $urandom;
  endtask

  // Issue one request and check the returned line, flags and latency, then
  // keep mem_req high for hold+1 cycles before releasing it for one cycle.
  task automatic run_req(input logic [31:0] addr, input int hold);
    logic [127:0] exp_line;
    int lat, cyc, last, n_acc;
    bit got;
    last = (cfg_err < 4) ? cfg_err : 3;
    lat  = (cfg_err < 4) ? 4 + cfg_err : 6;
    for (int k = 0; k <= last; k++) lat += cfg_wait[k];
    exp_line = '0;
    for (int k = 0; k < 4; k++) if (k < cfg_err) exp_line[32*k +: 32] = cfg_data[k];
    n_acc = (cfg_err < 3) ? cfg_err + 1 : 4;
    @(negedge clk);
    exp_base = {addr[31:4], 4'h0};
    acc_cnt  = 0;
    mem_req  = 1'b1;
    mem_addr = addr;
    cyc = 0; got = 0;
    while (cyc < 80 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) got = 1;
    end
    chk("ready_seen", got, 1'b1);
    chk("latency", cyc, lat);
    chk("mem_err", mem_err, (cfg_err < 4));
    chk("line", mem_data, exp_line);
    chk("accepted", acc_cnt, n_acc);
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      chk("pulse_once", mem_ready, 1'b0);
      chk("no_rearm", htrans, 2'b00);
      chk("data_hold", mem_data, exp_line);
    end
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    exp_base = '0; acc_cnt = 0; cfg_err = 4;
    for (int i = 0; i < 4; i++) begin cfg_wait[i] = 0; cfg_data[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_data", mem_data, 128'h0);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("hburst", hburst, 3'b011);
    chk("hsize", hsize, 3'b010);
    chk("hwrite", hwrite, 1'b0);
    chk("hprot", hprot, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait line with known data
    set_cfg(0, 0, 0, 0, 4);
    cfg_data[0] = 32'h11; cfg_data[1] = 32'h22; cfg_data[2] = 32'h33; cfg_data[3] = 32'h44;
    run_req(32'h0000_1234, 0);
    chk("line_known", mem_data, 128'h00000044_00000033_00000022_00000011);

    // two wait states on beat 1
    set_cfg(0, 2, 0, 0, 4);
    run_req(32'h0000_2000, 0);

    // held request for 10 cycles, then a new request
    set_cfg(0, 0, 0, 0, 4);
    run_req(32'h0000_3010, 10);
    set_cfg(0, 0, 0, 0, 4);
    run_req(32'h8000_0040, 0);

    // ERROR on beat 2
    set_cfg(0, 0, 0, 0, 2);
    run_req(32'h0000_4000, 1);

    // asynchronous reset while beat 2 is in its data phase
    set_cfg(0, 0, 0, 0, 4);
    @(negedge clk);
    exp_base = 32'h0000_5000; acc_cnt = 0;
    mem_req = 1'b1; mem_addr = 32'h0000_5008;
    begin
      int n = 0;
      while (n < 40 && acc_cnt < 3) begin @(negedge clk); #1; n++; end
      chk("reach_beat2", (acc_cnt >= 3), 1'b1);
    end
    chk("pre_rst_words", mem_data[63:0], {cfg_data[1], cfg_data[0]});
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("arst_haddr", haddr, 32'h0);
    chk("arst_htrans", htrans, 2'b00);
    chk("arst_data", mem_data, 128'h0);
    chk("arst_ready", mem_ready, 1'b0);
    chk("arst_err", mem_err, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_cfg(0, 0, 0, 0, 4);
    run_req(32'h0000_6000, 0);

    // top-of-memory line
    set_cfg(0, 1, 0, 0, 4);
    run_req(32'hFFFF_FFFF, 0);

    // randomized requests
    for (int t = 0; t < 24; t++) begin
      int w[4];
      int e;
      for (int i = 0; i < 4; i++) w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
      set_cfg(w[0], w[1], w[2], w[3], e);
      run_req($urandom, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
